// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader sitting in front of the multicycle MIPS core and its unified
//   memory. Takes a byte stream (16-bit little-endian word count N, then 4*N data
//   bytes), packs each group of four bytes into a little-endian word and writes the
//   words to memory from byte address 0 upward. The core is held off (cpu_run = 0)
//   until the last word has been written.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle load request, honoured only in IDLE or DONE
//   byte_valid  source presents byte_data
//   byte_data   stream byte
//   byte_ready  loader takes the byte this cycle (transfer = byte_valid & byte_ready)
//   mem_addr    word-aligned byte address of the write
//   mem_wdata   assembled write word
//   mem_write   one-cycle write strobe
//   cpu_run     core may execute
//   busy        load in progress
//   error       sticky, length header rejected
//
// All outputs are registered and reflect the state entered at the preceding edge.

module program_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        cpu_run,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    // One extra bit so a 16-bit count can be compared against MAX_WORDS = 65536.
    localparam logic [16:0] MaxLen = 17'(MAX_WORDS);

    state_e      state_q;
    logic [15:0] len_q;
    logic [15:0] index_q;
    logic [1:0]  cnt_q;
    logic [23:0] word_q;   // lanes 0..2; lane 3 goes straight into mem_wdata

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] index_inc;

    assign xfer      = byte_valid & byte_ready;
    assign len_full  = {byte_data, len_q[7:0]};
    assign index_inc = index_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            index_q    <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            byte_ready <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StLenLo;
                        index_q    <= '0;
                        cnt_q      <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        cpu_run    <= 1'b0;
                    end
                end

                StLenLo: begin
                    if (xfer) begin
                        len_q[7:0] <= byte_data;
                        state_q    <= StLenHi;
                    end
                end

                StLenHi: begin
                    if (xfer) begin
                        len_q[15:8] <= byte_data;
                        if ({1'b0, len_full} > MaxLen) begin
                            state_q    <= StError;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state_q    <= StDone;
                            cpu_run    <= 1'b1;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end

                StData: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: word_q[7:0]   <= byte_data;
                            2'd1: word_q[15:8]  <= byte_data;
                            2'd2: word_q[23:16] <= byte_data;
                            default: begin
                                // Fourth byte completes the word: present it in WRITE.
                                state_q    <= StWrite;
                                byte_ready <= 1'b0;
                                mem_write  <= 1'b1;
                                mem_addr   <= {14'b0, index_q, 2'b00};
                                mem_wdata  <= {byte_data, word_q};
                            end
                        endcase
                    end
                end

                StWrite: begin
                    index_q <= index_inc;
                    if (index_inc == len_q) begin
                        state_q <= StDone;
                        cpu_run <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_q    <= StData;
                        byte_ready <= 1'b1;
                    end
                end

                StError: begin
                    // Sticky until reset; start is ignored.
                end

                default: begin
                    state_q    <= StIdle;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    cpu_run    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives the byte stream on the falling edge,
// checks outputs on the falling edge, and logs every memory write at the rising edge.

module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        cpu_run;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    int          wr_count   = 0;
    int          xfer_count = 0;
    int          ready_viol = 0;
    logic [31:0] wr_addr [0:299];
    logic [31:0] wr_data [0:299];
    logic [31:0] prog    [0:255];

    program_loader #(.MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values seen here are those held during the cycle that this edge closes.
    always @(posedge clk) begin
        if (mem_write) begin
            if (wr_count < 300) begin
                wr_addr[wr_count] <= mem_addr;
                wr_data[wr_count] <= mem_wdata;
            end
            wr_count <= wr_count + 1;
            if (byte_ready) ready_viol <= ready_viol + 1;
        end
        if (byte_valid && byte_ready) xfer_count <= xfer_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int  n    = 0;
        bit  done = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!done && n < 100) begin
            done = byte_ready;
            @(negedge clk);
            n++;
        end
        byte_valid = 1'b0;
        if (!done) check("byte_timeout", 32'd0, 32'd1);
        if (stall) @(negedge clk);
    endtask

    // Header plus n words from prog[]; ends in the cycle after the last WRITE.
    task automatic load(input int n, input bit stall);
        logic [31:0] w;
        send_byte(8'(n), stall);
        send_byte(8'(n >> 8), stall);
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], stall && !(j == 3));
        end
        if (n > 0) @(negedge clk);
    endtask

    task automatic check_writes(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            check("wr_addr", wr_addr[base + i], 32'(i * 4));
            check("wr_data", wr_data[base + i], prog[i]);
        end
    endtask

    int wbase;
    int xbase;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        check("rst_flags", {27'b0, byte_ready, mem_write, cpu_run, busy, error}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", byte_ready, 1'b0);

        // Single word: 01 00 78 56 34 12
        wbase = wr_count;
        pulse_start();
        check("lenlo_ready", byte_ready, 1'b1);
        check("lenlo_busy", busy, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check("w1_write", mem_write, 1'b1);
        check("w1_addr", mem_addr, 32'h0);
        check("w1_data", mem_wdata, 32'h12345678);
        check("w1_ready", byte_ready, 1'b0);
        check("w1_run_low", cpu_run, 1'b0);
        @(negedge clk);
        check("w1_run", cpu_run, 1'b1);
        check("w1_busy", busy, 1'b0);
        check("w1_strobe_off", mem_write, 1'b0);
        check("w1_hold", mem_wdata, 32'h12345678);
        check("w1_count", 32'(wr_count - wbase), 32'd1);

        // Reload from DONE, three words back-to-back
        prog[0] = 32'hDEADBEEF;
        prog[1] = 32'h0BADF00D;
        prog[2] = 32'hCAFEBABE;
        wbase = wr_count;
        xbase = xfer_count;
        pulse_start();
        check("reload_run", cpu_run, 1'b0);
        check("reload_ready", byte_ready, 1'b1);
        load(3, 0);
        check("b2b_run", cpu_run, 1'b1);
        check("b2b_count", 32'(wr_count - wbase), 32'd3);
        check_writes(wbase, 3);
        check("b2b_xfers", 32'(xfer_count - xbase), 32'd14);

        // Same program with byte_valid toggling every other cycle
        prog[0] = 32'h01020304;
        prog[1] = 32'hA0B0C0D0;
        prog[2] = 32'h55AA33CC;
        wbase = wr_count;
        xbase = xfer_count;
        pulse_start();
        load(3, 1);
        check("stall_run", cpu_run, 1'b1);
        check("stall_count", 32'(wr_count - wbase), 32'd3);
        check_writes(wbase, 3);
        check("stall_xfers", 32'(xfer_count - xbase), 32'd14);
        check("ready_in_write", 32'(ready_viol), 32'd0);

        // Zero length
        wbase = wr_count;
        pulse_start();
        load(0, 0);
        check("zero_run", cpu_run, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_ready", byte_ready, 1'b0);
        @(negedge clk);
        check("zero_count", 32'(wr_count - wbase), 32'd0);

        // Maximum length
        for (int i = 0; i < 256; i++) prog[i] = (32'(i) * 32'h01000193) ^ 32'h5A5A5A5A;
        wbase = wr_count;
        pulse_start();
        load(256, 0);
        check("max_run", cpu_run, 1'b1);
        check("max_count", 32'(wr_count - wbase), 32'd256);
        check("max_last_addr", mem_addr, 32'h3FC);
        check_writes(wbase, 256);

        // Oversize length 257 = 01 01
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("ovr_error", error, 1'b1);
        check("ovr_ready", byte_ready, 1'b0);
        check("ovr_run", cpu_run, 1'b0);
        check("ovr_busy", busy, 1'b0);
        pulse_start();
        @(negedge clk);
        check("ovr_start_error", error, 1'b1);
        check("ovr_start_ready", byte_ready, 1'b0);
        check("ovr_start_busy", busy, 1'b0);
        do_reset();
        check("ovr_reset_error", error, 1'b0);

        // Reset after two of three words
        prog[0] = 32'h11223344;
        prog[1] = 32'h55667788;
        prog[2] = 32'h99AABBCC;
        wbase = wr_count;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) send_byte(prog[i][8*j +: 8], 0);
        check("mid_write2", mem_write, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_flags", {27'b0, byte_ready, mem_write, cpu_run, busy, error}, 32'h0);
        check("mid_addr", mem_addr, 32'h0);
        check("mid_wdata", mem_wdata, 32'h0);
        xbase = xfer_count;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        check("mid_no_xfer", 32'(xfer_count - xbase), 32'd0);
        check("mid_count", 32'(wr_count - wbase), 32'd2);
        check("mid_run", cpu_run, 1'b0);
        check_writes(wbase, 2);

        // Fresh load after the abandoned one
        prog[0] = 32'hA1B2C3D4;
        wbase = wr_count;
        pulse_start();
        load(1, 0);
        check("fresh_run", cpu_run, 1'b1);
        check("fresh_count", 32'(wr_count - wbase), 32'd1);
        check_writes(wbase, 1);

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rs_ready", byte_ready, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_run", cpu_run, 1'b0);
        @(negedge clk);
        check("rs_still_idle", byte_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
